theta: RTL and testbench

Iterative Keccak-f[1600] θ step for the SHAKE datapath. Sits directly upstream of ρ: accepts the 5×5×64 state on a start pulse, computes the five column parities one column per cycle, then applies the θ mix one column per cycle, and presents the result with a one-cycle valid pulse. The output array feeds ρ's `A` input unchanged, with the same `[x][y]` indexing.

---
 rtl/keccak_pkg.sv | 34 +++
 rtl/keccak_col_parity.sv | 23 ++
 rtl/theta.sv | 166 ++++++++++++++++
 tb/tb_theta.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keccak_pkg
// Purpose : Shared Keccak-f[1600] types, constants and small helpers used by
//           the theta, rho and later permutation stages.
// Contents: lane_t / state_t, KECCAK_DIM, KECCAK_W, rotl1, mod5_inc, mod5_dec
// Revision: 1.0 - initial release
// ============================================================================
package keccak_pkg;

  localparam int KECCAK_DIM = 5;
  localparam int KECCAK_W   = 64;

  typedef logic [KECCAK_W-1:0] lane_t;
  // Indexed [x][y], matching the lane addressing of every stage.
  typedef lane_t [KECCAK_DIM-1:0][KECCAK_DIM-1:0] state_t;

  // Rotate a lane left by one bit.
  function automatic lane_t rotl1(input lane_t v);
    return {v[KECCAK_W-2:0], v[KECCAK_W-1]};
  endfunction

  // (v + 1) mod 5 by compare-and-wrap; only 0..4 are meaningful.
  function automatic logic [2:0] mod5_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // (v + 4) mod 5 by compare-and-wrap; only 0..4 are meaningful.
  function automatic logic [2:0] mod5_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
  endfunction

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_col_parity.sv
`default_nettype none
// ============================================================================
// Module  : keccak_col_parity
// Purpose : Combinational parity of one Keccak column (XOR of its five lanes).
// Ports   : lane0_i..lane4_i - the five lanes S[x][0..4] of a column
//           parity_o         - C[x] = XOR of the five lanes
// Revision: 1.0 - initial release
// ============================================================================
module keccak_col_parity
  import keccak_pkg::*;
(
  input  lane_t lane0_i,
  input  lane_t lane1_i,
  input  lane_t lane2_i,
  input  lane_t lane3_i,
  input  lane_t lane4_i,
  output lane_t parity_o
);

  assign parity_o = lane0_i ^ lane1_i ^ lane2_i ^ lane3_i ^ lane4_i;

endmodule : keccak_col_parity
`default_nettype wire

// File: rtl/theta.sv
`default_nettype none
// ============================================================================
// Module  : theta
// Purpose : Iterative Keccak-f[1600] theta step. Latches the state on start,
//           computes column parities one column per cycle, then applies the
//           theta mix one column per cycle and pulses valid for one cycle.
// Ports   : clk     - rising-edge clock
//           rst     - asynchronous active-low reset
//           start   - run request, only sampled while idle
//           A       - input state, lane A[x][y]
//           A_prime - theta output state, same [x][y] indexing (feeds rho)
//           valid   - one-cycle pulse, A_prime complete
//           busy    - high from acceptance until the cycle after valid
// Revision: 1.0 - initial release
// ============================================================================
module theta
  import keccak_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4:0][4:0][W-1:0] A,
  output logic [4:0][4:0][W-1:0] A_prime,
  output logic                   valid,
  output logic                   busy
);

  if (W != KECCAK_W) begin : g_w_check
    $error("theta: only W = 64 is supported");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARITY = 2'd1,
    ST_APPLY  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic   [2:0]   x_q, x_d;
  state_t         S_q;
  lane_t  [4:0]   C_q;
  state_t         A_prime_q;

  logic           load_s;
  logic           wr_c;
  logic           wr_ap;
  logic   [2:0]   col_idx;
  logic   [2:0]   xm1;
  logic   [2:0]   xp1;
  lane_t          parity;
  lane_t          mix;

  // Out-of-range counter values never index the arrays; the FSM leaves for
  // IDLE in that case and no write is enabled.
  assign col_idx = (x_q > 3'd4) ? 3'd0 : x_q;
  assign xm1     = mod5_dec(col_idx);
  assign xp1     = mod5_inc(col_idx);
  assign mix     = C_q[xm1] ^ rotl1(C_q[xp1]);

  keccak_col_parity u_col_parity (
    .lane0_i  (S_q[col_idx][0]),
    .lane1_i  (S_q[col_idx][1]),
    .lane2_i  (S_q[col_idx][2]),
    .lane3_i  (S_q[col_idx][3]),
    .lane4_i  (S_q[col_idx][4]),
    .parity_o (parity)
  );

  // --------------------------------------------------------------------------
  // FSM: next-state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    load_s  = 1'b0;
    wr_c    = 1'b0;
    wr_ap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          x_d     = 3'd0;
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (x_q > 3'd4) begin
          x_d     = 3'd0;
          state_d = ST_IDLE;
        end else begin
          wr_c = 1'b1;
          if (x_q == 3'd4) begin
            x_d     = 3'd0;
            state_d = ST_APPLY;
          end else begin
            x_d = x_q + 3'd1;
          end
        end
      end
      ST_APPLY: begin
        if (x_q > 3'd4) begin
          x_d     = 3'd0;
          state_d = ST_IDLE;
        end else begin
          wr_ap = 1'b1;
          if (x_q == 3'd4) begin
            x_d     = 3'd0;
            state_d = ST_DONE;
          end else begin
            x_d = x_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        x_d     = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      S_q       <= '0;
      C_q       <= '0;
      A_prime_q <= '0;
    end else begin
      if (load_s) begin
        S_q <= A;
      end
      if (wr_c) begin
        C_q[col_idx] <= parity;
      end
      if (wr_ap) begin
        for (int y = 0; y < KECCAK_DIM; y++) begin
          A_prime_q[col_idx][y] <= S_q[col_idx][y] ^ mix;
        end
      end
    end
  end

  // All outputs come straight from registers.
  assign A_prime = A_prime_q;
  assign valid   = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);

endmodule : theta
`default_nettype wire

// File: tb/tb_theta.sv
`default_nettype none
// ============================================================================
// Module  : tb_theta
// Purpose : Self-checking bench for theta against a textbook theta model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_theta;
  import keccak_pkg::*;

  logic   clk;
  logic   rst;
  logic   start;
  state_t A;
  state_t A_prime;
  logic   valid;
  logic   busy;

  int n_tests = 0;
  int n_fail  = 0;

  theta #(.W(64)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .A_prime (A_prime),
    .valid   (valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t exp);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        check($sformatf("%s[%0d][%0d]", tag, x, y), A_prime[x][y], exp[x][y]);
  endtask

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // Textbook theta: C[x] = xor over column, D[x] = C[x-1] ^ ROT(C[x+1], 1).
  function automatic state_t theta_ref(input state_t a);
    logic [63:0] c [5];
    logic [63:0] d;
    state_t      r;
    for (int x = 0; x < 5; x++) begin
      c[x] = 64'h0;
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[x][y];
    end
    for (int x = 0; x < 5; x++) begin
      d = c[(x + 4) % 5] ^ ((c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> 63));
      for (int y = 0; y < 5; y++) r[x][y] = a[x][y] ^ d;
    end
    return r;
  endfunction

  // One run: accept a at the next edge, watch a bounded window, then compare.
  // With disturb set, A is scrambled and start re-pulsed while busy.
  task automatic run_theta(input string tag, input state_t a, input state_t exp, input bit disturb);
    int nvalid = 0;
    int vcyc   = -1;
    A     = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":busy_acc"}, {63'h0, busy}, 64'h1);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (disturb && c == 1) A = rand_state();
      if (disturb && c == 3) start = 1'b1;
      if (disturb && c == 4) start = 1'b0;
      if (valid) begin
        nvalid++;
        vcyc = c;
      end
      if (c == 10) check({tag, ":busy10"}, {63'h0, busy}, 64'h1);
      if (c == 11) check({tag, ":busy11"}, {63'h0, busy}, 64'h0);
    end
    check({tag, ":nvalid"}, 64'(nvalid), 64'd1);
    check({tag, ":vcycle"}, 64'(vcyc), 64'd10);
    check_state({tag, ":Ap"}, exp);
  endtask

  initial begin
    state_t a;
    state_t e;
    int     nv;

    // Reset held with start and random A.
    rst   = 1'b0;
    start = 1'b1;
    A     = rand_state();
    repeat (3) @(posedge clk);
    #1;
    check("rst:valid", {63'h0, valid}, 64'h0);
    check("rst:busy",  {63'h0, busy},  64'h0);
    check_state("rst:Ap", '0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rel:valid", {63'h0, valid}, 64'h0);
    check("rel:busy",  {63'h0, busy},  64'h0);
    check_state("rel:Ap", '0);

    // All-zero state.
    run_theta("zero", '0, '0, 1'b0);

    // Single bit in A[0][0].
    a = '0; a[0][0] = 64'h1;
    e = '0; e[0][0] = 64'h1;
    for (int y = 0; y < 5; y++) begin
      e[1][y] = 64'h1;
      e[4][y] = 64'h2;
    end
    run_theta("bit00", a, e, 1'b0);

    // Rotation wrap from the top bit of A[2][0].
    a = '0; a[2][0] = 64'h8000_0000_0000_0000;
    e = '0; e[2][0] = 64'h8000_0000_0000_0000;
    for (int y = 0; y < 5; y++) begin
      e[3][y] = 64'h8000_0000_0000_0000;
      e[1][y] = 64'h1;
    end
    run_theta("wrap", a, e, 1'b0);

    // Random vectors, with idle gaps of varying length.
    for (int i = 0; i < 4; i++) begin
      a = rand_state();
      run_theta($sformatf("rand%0d", i), a, theta_ref(a), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Start while busy and A changed mid-run.
    a = rand_state();
    run_theta("disturb", a, theta_ref(a), 1'b1);

    // Reset mid-run at acceptance+7.
    a     = rand_state();
    A     = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst:valid", {63'h0, valid}, 64'h0);
    check("midrst:busy",  {63'h0, busy},  64'h0);
    check_state("midrst:Ap", '0);
    @(posedge clk); #1;
    rst = 1'b1;
    nv  = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check("midrst:novalid", 64'(nv), 64'd0);
    check_state("midrst:hold", '0);

    // Fresh run after the abort.
    a = rand_state();
    run_theta("after_rst", a, theta_ref(a), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_theta
`default_nettype wire
